calc_req_frontend: RTL

Request-side front end of the four-port calculator DUT, directly downstream of the testbench interface's request pins. For each port it captures the two-cycle request protocol: command, operand 1 and tag, then operand 2 on the following cycle. It rejects requests whose tag is still outstanding and queues accepted requests per port. A round-robin arbiter dispatches them one at a time to the shared ALU through a valid/ready handshake.

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_port_queue.sv | 155 +++++++++++++++
 rtl/calc_port_queue_chk.sv | 12 +
 rtl/calc_req_frontend.sv | 95 +++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator request definitions: widths, command codes, request record
// and the small index helpers used by the request front end.
package calc_pkg;

    localparam int NUM_PORTS      = 4;
    localparam int PORT_W         = 2;
    localparam int REQ_CMD_WIDTH  = 4;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int REQ_TAG_WIDTH  = 2;
    localparam int TAG_NUM        = 2 ** REQ_TAG_WIDTH;

    localparam logic [PORT_W:0]   PORT_COUNT = (PORT_W + 1)'(NUM_PORTS);
    localparam logic [PORT_W-1:0] PORT_ONE   = {{(PORT_W - 1){1'b0}}, 1'b1};

    typedef enum logic [REQ_CMD_WIDTH-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } calc_cmd_e;

    typedef enum logic [0:0] {
        CAP_IDLE = 1'b0,
        CAP_OP2  = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic [REQ_CMD_WIDTH-1:0]  cmd;
        logic [REQ_DATA_WIDTH-1:0] op1;
        logic [REQ_DATA_WIDTH-1:0] op2;
        logic [REQ_TAG_WIDTH-1:0]  tag;
    } calc_req_t;

    localparam int REQ_W = $bits(calc_req_t);

    // Port index `offset` positions after `base`, wrapping at NUM_PORTS.
    function automatic logic [PORT_W-1:0] rrIndex(input logic [PORT_W-1:0] base,
                                                  input logic [PORT_W-1:0] offset);
        logic [PORT_W:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        return (sum >= PORT_COUNT) ? PORT_W'(sum - PORT_COUNT) : sum[PORT_W-1:0];
    endfunction

    function automatic logic [TAG_NUM-1:0] tagMask(input logic [REQ_TAG_WIDTH-1:0] tag);
        return {{(TAG_NUM - 1){1'b0}}, 1'b1} << tag;
    endfunction

endpackage

// File: rtl/calc_port_queue.sv
// One requester port: two-cycle request capture, outstanding-tag tracking and
// the per-port request FIFO feeding the dispatch arbiter.
module calc_port_queue
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [REQ_CMD_WIDTH-1:0]  reqCmd,
    input  logic [REQ_DATA_WIDTH-1:0] reqData,
    input  logic [REQ_TAG_WIDTH-1:0]  reqTag,
    input  logic                      cplHit,
    input  logic [REQ_TAG_WIDTH-1:0]  cplTag,
    input  logic                      pop,
    output logic [REQ_W-1:0]          head,
    output logic                      empty,
    output logic                      tagErr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W - 1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

    cap_state_e                 state_r;
    cap_state_e                 stateNext_s;
    logic                       capture_s;
    logic                       complete_s;
    logic [REQ_CMD_WIDTH-1:0]   cmd_r;
    logic [REQ_DATA_WIDTH-1:0]  op1_r;
    logic [REQ_TAG_WIDTH-1:0]   tag_r;
    logic [TAG_NUM-1:0]         outst_r;
    logic [TAG_NUM-1:0]         outstClr_s;
    logic [TAG_NUM-1:0]         outstNext_s;
    logic                       accept_s;
    logic                       reject_s;
    logic                       full_s;
    logic                       push_s;
    logic                       doPop_s;
    calc_req_t                  pushEntry_s;
    calc_req_t                  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]           wrPtr_r;
    logic [PTR_W-1:0]           rdPtr_r;
    logic [PTR_W:0]             count_r;
    logic                       tagErr_r;

    // Capture state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= CAP_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Capture sequencing: a non-zero cmd opens a request, the next cycle closes it.
    always_comb begin
        stateNext_s = state_r;
        capture_s   = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            CAP_IDLE: begin
                if (reqCmd != '0) begin
                    stateNext_s = CAP_OP2;
                    capture_s   = 1'b1;
                end else begin
                    stateNext_s = CAP_IDLE;
                end
            end
            CAP_OP2: begin
                stateNext_s = CAP_IDLE;
                complete_s  = 1'b1;
            end
            default: stateNext_s = CAP_IDLE;
        endcase
    end

    // First-cycle fields of the request being captured.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cmd_r <= '0;
            op1_r <= '0;
            tag_r <= '0;
        end else if (capture_s) begin
            cmd_r <= reqCmd;
            op1_r <= reqData;
            tag_r <= reqTag;
        end
    end

    // Tag check; a completion in the same cycle frees its tag before the check.
    always_comb begin
        outstClr_s        = cplHit ? (outst_r & ~tagMask(cplTag)) : outst_r;
        accept_s          = complete_s && !outstClr_s[tag_r];
        reject_s          = complete_s && outstClr_s[tag_r];
        outstNext_s       = accept_s ? (outstClr_s | tagMask(tag_r)) : outstClr_s;
        full_s            = (count_r == CNT_FULL);
        push_s            = accept_s && !full_s;
        doPop_s           = pop && (count_r != '0);
        pushEntry_s.cmd   = cmd_r;
        pushEntry_s.op1   = op1_r;
        pushEntry_s.op2   = reqData;
        pushEntry_s.tag   = tag_r;
    end

    // Outstanding tags and the one-cycle drop pulse.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outst_r  <= '0;
            tagErr_r <= 1'b0;
        end else begin
            outst_r  <= outstNext_s;
            tagErr_r <= reject_s;
        end
    end

    // Request FIFO storage and pointers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wrPtr_r] <= pushEntry_s;
                wrPtr_r        <= (wrPtr_r == PTR_LAST) ? '0 : wrPtr_r + PTR_ONE;
            end
            if (doPop_s) begin
                rdPtr_r <= (rdPtr_r == PTR_LAST) ? '0 : rdPtr_r + PTR_ONE;
            end
            case ({push_s, doPop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head   = mem_r[rdPtr_r];
    assign empty  = (count_r == '0);
    assign tagErr = tagErr_r;

    calc_port_queue_chk u_chk (
        .clk  (clk),
        .rstN (rstN),
        .push (accept_s),
        .full (full_s)
    );

endmodule

// File: rtl/calc_port_queue_chk.sv
// Property checker for one request port queue.
module calc_port_queue_chk (
    input logic clk,
    input logic rstN,
    input logic push,
    input logic full
);

    // Tag accounting bounds the queue; a push into a full queue is lost.
    a_noPushWhenFull: assert property (@(posedge clk) disable iff (!rstN) !(push && full));

endmodule

// File: rtl/calc_req_frontend.sv
// Calculator request front end: per-port capture queues, round-robin dispatch
// arbiter and the registered valid/ready dispatch stage towards the ALU.
module calc_req_frontend
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                ifClk,
    input  logic                                ifRst,
    input  logic [NUM_PORTS*REQ_CMD_WIDTH-1:0]  ifReq_cmd_in,
    input  logic [NUM_PORTS*REQ_DATA_WIDTH-1:0] ifReq_data_in,
    input  logic [NUM_PORTS*REQ_TAG_WIDTH-1:0]  ifReq_tag_in,
    output logic                                disp_valid,
    input  logic                                disp_ready,
    output logic [1:0]                          disp_port,
    output logic [REQ_CMD_WIDTH-1:0]            disp_cmd,
    output logic [REQ_DATA_WIDTH-1:0]           disp_op1,
    output logic [REQ_DATA_WIDTH-1:0]           disp_op2,
    output logic [REQ_TAG_WIDTH-1:0]            disp_tag,
    input  logic                                cpl_valid,
    input  logic [1:0]                          cpl_port,
    input  logic [REQ_TAG_WIDTH-1:0]            cpl_tag,
    output logic [NUM_PORTS-1:0]                tag_err
);

    logic [REQ_W-1:0]     head_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty_s;
    logic [NUM_PORTS-1:0] pop_s;
    logic                 winValid_s;
    logic [PORT_W-1:0]    winPort_s;
    logic                 loadEn_s;
    logic [PORT_W-1:0]    rrPtr_r;
    logic                 dispValid_r;
    logic [PORT_W-1:0]    dispPort_r;
    calc_req_t            dispReq_r;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_port_queue #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_queue (
            .clk     (ifClk),
            .rstN    (ifRst),
            .reqCmd  (ifReq_cmd_in[p*REQ_CMD_WIDTH +: REQ_CMD_WIDTH]),
            .reqData (ifReq_data_in[p*REQ_DATA_WIDTH +: REQ_DATA_WIDTH]),
            .reqTag  (ifReq_tag_in[p*REQ_TAG_WIDTH +: REQ_TAG_WIDTH]),
            .cplHit  (cpl_valid && (cpl_port == PORT_W'(p))),
            .cplTag  (cpl_tag),
            .pop     (pop_s[p]),
            .head    (head_s[p]),
            .empty   (empty_s[p]),
            .tagErr  (tag_err[p])
        );
    end

    // Round-robin pick: scan from the far end so the port nearest rrPtr wins.
    always_comb begin
        winValid_s = 1'b0;
        winPort_s  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            winPort_s  = empty_s[rrIndex(rrPtr_r, PORT_W'(i))] ? winPort_s
                                                                : rrIndex(rrPtr_r, PORT_W'(i));
            winValid_s = winValid_s | !empty_s[rrIndex(rrPtr_r, PORT_W'(i))];
        end
        loadEn_s = !dispValid_r || disp_ready;
        pop_s    = (loadEn_s && winValid_s) ? ({{(NUM_PORTS - 1){1'b0}}, 1'b1} << winPort_s)
                                            : '0;
    end

    // Dispatch register: reload whenever empty or handed off this cycle.
    always_ff @(posedge ifClk or negedge ifRst) begin
        if (!ifRst) begin
            dispValid_r <= 1'b0;
            dispPort_r  <= '0;
            dispReq_r   <= '0;
            rrPtr_r     <= '0;
        end else if (loadEn_s) begin
            if (winValid_s) begin
                dispValid_r <= 1'b1;
                dispPort_r  <= winPort_s;
                dispReq_r   <= calc_req_t'(head_s[winPort_s]);
                rrPtr_r     <= rrIndex(winPort_s, PORT_ONE);
            end else begin
                dispValid_r <= 1'b0;
            end
        end
    end

    assign disp_valid = dispValid_r;
    assign disp_port  = dispPort_r;
    assign disp_cmd   = dispReq_r.cmd;
    assign disp_op1   = dispReq_r.op1;
    assign disp_op2   = dispReq_r.op2;
    assign disp_tag   = dispReq_r.tag;

endmodule
